// File: rtl/dps_enc_11_seq.sv
// dps_enc_11_seq: bit-serial greedy FNS encoder producing the 11-bit DPS codeword with valid/ready on both sides.
`ifndef DBLEN11
`define DBLEN11 9
`endif
`ifndef FNS01
`define FNS01 1
`define FNS02 2
`define FNS03 3
`define FNS04 5
`define FNS05 8
`define FNS06 13
`define FNS07 21
`define FNS08 34
`define FNS09 55
`define FNS10 55
`define FNS11 89
`endif

module dps_enc_11_seq #(
  parameter int DBLEN = `DBLEN11,
  parameter int CWLEN = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DBLEN-1:0] datain,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [10:0]      codeout,
  output logic             err
);
  if (CWLEN != 11) begin : g_bad_cwlen
    $error("dps_enc_11_seq supports only CWLEN == 11");
  end
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int WB [11] = '{`FNS01, `FNS02, `FNS03, `FNS04, `FNS05, `FNS06,
                             `FNS07, `FNS08, `FNS09, 2*`FNS10, `FNS11};
  state_t       state_q, state_d;
  logic [DBLEN:0] res_q, res_d, w, nxt;
  logic [3:0]   idx_q, idx_d;
  logic [10:0]  code_q, code_d, cout_q, cout_d;
  logic         err_q, err_d, ge;
  assign w   = (DBLEN+1)'(WB[idx_q]);
  assign ge  = res_q >= w;
  assign nxt = ge ? res_q - w : res_q;
  // Codeword bits are shifted in from the LSB, so after 11 steps bit 10 holds the first decision.
  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    idx_d   = idx_q;
    code_d  = code_q;
    cout_d  = cout_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (in_valid) begin
        state_d = RUN;
        res_d   = {1'b0, datain};
        code_d  = '0;
        idx_d   = 4'd10;
      end
      RUN: begin
        res_d  = nxt;
        code_d = {code_q[9:0], ge};
        idx_d  = idx_q - 4'd1;
        if (idx_q == 4'd0) begin
          state_d = DONE;
          cout_d  = {code_q[9:0], ge};
          err_d   = nxt != '0;
          idx_d   = 4'd10;
        end
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      res_q   <= '0;
      idx_q   <= 4'd10;
      code_q  <= '0;
      cout_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      idx_q   <= idx_d;
      code_q  <= code_d;
      cout_q  <= cout_d;
      err_q   <= err_d;
    end
  end
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign codeout   = cout_q;
  assign err       = err_q;
endmodule

// File: tb/tb_dps_enc_11_seq.sv
// tb_dps_enc_11_seq: directed vector table plus handshake, sweep and reset-abort sequences for dps_enc_11_seq.
module tb_dps_enc_11_seq;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
  logic [8:0] datain = '0;
  logic in_ready, out_valid, err;
  logic [10:0] codeout;
  int tests = 0, fails = 0, cyc = 0;
  int wt [11] = '{1, 2, 3, 5, 8, 13, 21, 34, 55, 110, 89};
  typedef struct {logic [8:0] d; logic [10:0] c; logic e;} vec_t;
  vec_t tv [10];

  dps_enc_11_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .datain(datain), .out_valid(out_valid), .out_ready(out_ready),
    .codeout(codeout), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string n, input int a, input int x);
    tests++;
    if (a != x) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d", n, a, x);
    end
  endtask

  function automatic int dec(input logic [10:0] c);
    int s = 0;
    for (int i = 0; i < 11; i++) if (c[i]) s += wt[i];
    return s;
  endfunction

  task automatic run_one(input logic [8:0] d, input bit noise, output logic [10:0] c, output logic e);
    int lat;
    @(negedge clk);
    chk("in_ready_idle", in_ready, 1);
    datain = d;
    in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    chk("in_ready_drop", in_ready, 0);
    lat = 1;
    while (!out_valid && lat < 40) begin
      if (noise) begin
        datain = 9'($urandom);
        in_valid = lat < 8;
      end
      @(negedge clk);
      lat++;
    end
    in_valid = 0;
    chk("latency", lat, 12);
    c = codeout;
    e = err;
  endtask

  task automatic release_out();
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    chk("out_valid_fall", out_valid, 0);
    chk("in_ready_back", in_ready, 1);
  endtask

  initial begin
    logic [10:0] c;
    logic e;
    int sent, got, guard, last, expv;
    bit chg, first;
    tv[0] = '{9'd0,   11'h000, 1'b0};
    tv[1] = '{9'd144, 11'h500, 1'b0};
    tv[2] = '{9'd110, 11'h440, 1'b0};
    tv[3] = '{9'd342, 11'h7FF, 1'b1};
    tv[4] = '{9'd341, 11'h7FF, 1'b0};
    tv[5] = '{9'd1,   11'h001, 1'b0};
    tv[6] = '{9'd143, 11'h4AA, 1'b0};
    tv[7] = '{9'd511, 11'h7FF, 1'b1};
    tv[8] = '{9'd88,  11'h155, 1'b0};
    tv[9] = '{9'd200, 11'h601, 1'b0};
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_codeout", codeout, 0);
    chk("rst_err", err, 0);
    repeat (3) @(negedge clk);
    rst_n = 1;

    for (int i = 0; i < 10; i++) begin
      run_one(tv[i].d, i[0], c, e);
      chk($sformatf("code[%0d]", i), c, tv[i].c);
      chk($sformatf("err[%0d]", i), e, tv[i].e);
      if (!tv[i].e) chk($sformatf("roundtrip[%0d]", i), dec(c), tv[i].d);
      release_out();
    end

    run_one(9'd144, 0, c, e);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_code", codeout, 11'h500);
    end
    release_out();

    run_one(9'd110, 0, c, e);
    chk("bit10_first", c[10], 1);
    chk("dec_2fns10", dec(c), 110);
    release_out();

    out_ready = 1;
    datain = '0;
    in_valid = 1;
    sent = 0; got = 0; guard = 0; last = 0; expv = 0; chg = 0; first = 1;
    while (got < 342 && guard < 6000) begin
      @(negedge clk);
      guard++;
      if (chg) begin
        datain = 9'(sent);
        chg = 0;
        if (sent == 342) in_valid = 0;
      end
      if (out_valid) begin
        chk("sweep_err", err, 0);
        chk("sweep_dec", dec(codeout), expv);
        got++;
      end
      if (in_ready && in_valid) begin
        if (!first) chk("sweep_spacing", cyc - last, 13);
        first = 0;
        last = cyc;
        expv = sent;
        sent++;
        chg = 1;
      end
    end
    if (got < 342) chk("sweep_timeout", got, 342);
    @(negedge clk);
    out_ready = 0;
    in_valid = 0;

    @(negedge clk);
    datain = 9'd143;
    in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    repeat (4) @(negedge clk);
    rst_n = 0;
    #1;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_codeout", codeout, 0);
    chk("abort_valid", out_valid, 0);
    @(negedge clk);
    rst_n = 1;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      chk("abort_no_valid", out_valid, 0);
    end
    chk("abort_idle", in_ready, 1);
    run_one(9'd143, 0, c, e);
    chk("after_abort_code", c, 11'h4AA);
    chk("after_abort_err", e, 0);
    release_out();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/dps_enc_11_seq.md
Name: dps_enc_11_seq

Overview:
- Sequential DPS encoder for the 11-bit crosstalk-avoidance code path. Sits directly upstream of the 11-bit DPS decoder.
- Converts a binary data word into an 11-bit codeword, one bit per clock, by greedy subtraction of the FNS weights.
- The decoder applied to the emitted codeword must reproduce the input data exactly.
- Valid/ready handshake on both sides, so it can be placed between pipeline stages.

Parameters:
- DBLEN, `DBLEN11, width of the binary data word; must match the decoder's output width.
- CWLEN, 11, codeword width; fixed. Other values are unsupported, and elaboration must fail if CWLEN is not 11.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  data word is offered this cycle
- in_ready  out  1  encoder can accept a word
- datain  in  DBLEN  binary data to encode
- out_valid  out  1  codeout and err are valid
- out_ready  in  1  downstream consumes the result
- codeout  out  11  encoded codeword
- err  out  1  residual was nonzero after bit 0; the value is not representable

Behaviour:
- Weight table W[i], shared with the decoder and taken from FNS.vh:
  - W[0..8] = `FNS01..`FNS09
  - W[9] = 2*`FNS10
  - W[10] = `FNS11
- All arithmetic is unsigned, DBLEN+1 bits wide; the residual never goes negative.
- States: IDLE, RUN, DONE.
- Reset (async, rst_n=0):
  - state=IDLE, in_ready=1, out_valid=0, codeout=0, err=0
  - internal residual=0, bit index=10
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready: load residual=datain, clear codeword register, index=10, go to RUN.
- RUN (in_ready=0), one index per cycle, i = 10 down to 0:
  - If residual >= W[i]: code[i]=1 and residual -= W[i]; otherwise code[i]=0.
  - After i=0 is processed: err = (residual != 0), go to DONE.
  - RUN lasts exactly 11 cycles.
- DONE:
  - out_valid=1. codeout and err are stable and held until out_ready.
  - On out_valid & out_ready: out_valid=0 and go to IDLE. The next word is accepted no earlier than the following cycle (no bypass).
- Latency: the accept edge to the first cycle of out_valid is 12 clocks. Peak throughput is one word per 13 clocks.
- codeout holds its last value outside DONE. Only out_valid qualifies it.
- in_valid is ignored in RUN and DONE. datain is sampled only on the accept edge, so later changes to datain have no effect.
- out_ready asserted while out_valid=0 has no effect.
- Reset asserted mid-RUN or in DONE aborts the operation immediately:
  - no output is produced
  - after release the block is in IDLE with reset values
- Maximum encodable value is sum W[0..10]. Inputs above it, or values the greedy pass cannot reach, finish with err=1. codeout is still the greedy pattern.
- Round-trip requirement: if err=0, decoder(codeout) == datain.

Test Plan:
1. Reset then datain=0, in_valid for one cycle -> in_ready drops the next cycle; after 12 clocks out_valid=1, codeout=11'b000_0000_0000, err=0.
2. datain=`FNS11+`FNS09 -> codeout=11'b101_0000_0000, err=0. Hold out_ready=0 for 5 cycles: out_valid and codeout stay stable. Then pulse out_ready: out_valid falls and in_ready=1 the next cycle.
3. datain=2*`FNS10 -> greedy picks bit10 first. codeout has bit10=1, and the decoder's output equals 2*`FNS10, err=0.
4. Exhaustive sweep of datain=0..sum W, back-to-back, with out_ready tied high -> every result has err=0 and decoder(codeout)==datain. Spacing between accepts is 13 cycles.
5. datain=sum W + 1 -> codeout=11'b111_1111_1111, err=1.
6. Assert rst_n=0 at RUN cycle 5, then release -> no out_valid pulse, in_ready=1, codeout=0. The next word encodes correctly.
